// File: rtl/sweep_pkg.sv
// Shared types for the exhaustive stimulus/capture sweep.
// State encoding and the pattern-count helper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } sweep_state_t;

    function automatic int nvec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/vector_sweep_capture.sv
// Drives every input pattern to a circuit, captures its output per pattern,
// and reports the response word against a golden word.
module vector_sweep_capture
    import sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1,
    localparam int NVEC  = nvec(N_IN)
) (
    input  logic            CK,
    input  logic            reset,
    input  logic            start,
    input  logic [NVEC-1:0] golden,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [NVEC-1:0] resp,
    output logic            mismatch,
    output logic [N_IN-1:0] fail_idx
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NVEC-1:0] gold_q, gold_d;
    logic [NVEC-1:0] resp_q, resp_d;
    logic            mis_q, mis_d;
    logic [N_IN-1:0] fail_q, fail_d;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gold_q  <= '0;
            resp_q  <= '0;
            mis_q   <= 1'b0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gold_q  <= gold_d;
            resp_q  <= resp_d;
            mis_q   <= mis_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gold_d  = gold_q;
        resp_d  = resp_q;
        mis_d   = mis_q;
        fail_d  = fail_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    gold_d  = golden;
                    idx_d   = '0;
                    cnt_d   = '0;
                    resp_d  = '0;
                    mis_d   = 1'b0;
                    fail_d  = '0;
                end
            end
            DRIVE: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    resp_d[idx_q] = dut_out;
                    // only the first differing pattern is reported
                    if (dut_out != gold_q[idx_q] && !mis_q) begin
                        mis_d  = 1'b1;
                        fail_d = idx_q;
                    end
                    cnt_d = '0;
                    if (idx_q == '1) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                    end
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dut_in     = idx_q;
    assign busy       = (state_q == DRIVE);
    assign resp_valid = (state_q == DONE);
    assign resp       = resp_q;
    assign mismatch   = mis_q;
    assign fail_idx   = fail_q;

endmodule

// File: tb/tb_vector_sweep_capture.sv
// Bench: two sweep instances (SETTLE=1 and SETTLE=0) against a sweep-level
// model plus hand-computed expectations.
module tb_vector_sweep_capture;

    logic       CK;
    logic       reset;
    logic       start_s[2];
    logic       ready_s[2];
    logic       dout_s[2];
    logic       busy_s[2];
    logic       valid_s[2];
    logic       mis_s[2];
    logic [7:0] gold_s[2];
    logic [7:0] resp_s[2];
    logic [2:0] din_s[2];
    logic [2:0] fail_s[2];
    int         sel_s[2];

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    // model state: 0 idle, 1 sweeping, 2 result held
    int         m_st[2];
    int         m_t[2];
    logic [7:0] m_g[2];
    logic [7:0] m_resp[2];
    logic       m_mis[2];
    logic [2:0] m_din[2];
    logic [2:0] m_fail[2];

    function automatic logic circ_fn(input int sel, input logic [2:0] v);
        if (sel == 0) return &v;
        return ^v;
    endfunction

    function automatic int st(input int j);
        return (j == 0) ? 1 : 0;
    endfunction

    always_comb begin
        dout_s[0] = circ_fn(sel_s[0], din_s[0]);
        dout_s[1] = circ_fn(sel_s[1], din_s[1]);
    end

    vector_sweep_capture #(.N_IN(3), .SETTLE(1)) u_a (
        .CK(CK), .reset(reset), .start(start_s[0]), .golden(gold_s[0]),
        .dut_in(din_s[0]), .dut_out(dout_s[0]), .busy(busy_s[0]),
        .resp_valid(valid_s[0]), .resp_ready(ready_s[0]),
        .resp(resp_s[0]), .mismatch(mis_s[0]), .fail_idx(fail_s[0])
    );

    vector_sweep_capture #(.N_IN(3), .SETTLE(0)) u_b (
        .CK(CK), .reset(reset), .start(start_s[1]), .golden(gold_s[1]),
        .dut_in(din_s[1]), .dut_out(dout_s[1]), .busy(busy_s[1]),
        .resp_valid(valid_s[1]), .resp_ready(ready_s[1]),
        .resp(resp_s[1]), .mismatch(mis_s[1]), .fail_idx(fail_s[1])
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // sweep model: timing from cycles since accept, result from the circuit
    always @(posedge CK or negedge reset) begin
        for (int j = 0; j < 2; j++) begin
            if (!reset) begin
                m_st[j]   = 0;
                m_t[j]    = 0;
                m_din[j]  = 3'd0;
                m_resp[j] = 8'd0;
                m_mis[j]  = 1'b0;
                m_fail[j] = 3'd0;
                m_g[j]    = 8'd0;
            end else begin
                case (m_st[j])
                    0: if (start_s[j]) begin
                        m_st[j]   = 1;
                        m_t[j]    = 0;
                        m_g[j]    = gold_s[j];
                        m_din[j]  = 3'd0;
                        m_resp[j] = 8'd0;
                        m_mis[j]  = 1'b0;
                        m_fail[j] = 3'd0;
                    end
                    1: begin
                        m_t[j]++;
                        if (m_t[j] == 8 * (st(j) + 1)) begin
                            logic [7:0] w;
                            m_st[j]  = 2;
                            m_din[j] = 3'd7;
                            for (int i = 0; i < 8; i++)
                                w[i] = circ_fn(sel_s[j], 3'(i));
                            m_resp[j] = w;
                            m_mis[j]  = (w != m_g[j]);
                            m_fail[j] = 3'd0;
                            for (int i = 7; i >= 0; i--)
                                if (w[i] != m_g[j][i]) m_fail[j] = 3'(i);
                        end else begin
                            m_din[j] = 3'(m_t[j] / (st(j) + 1));
                        end
                    end
                    2: if (ready_s[j]) m_st[j] = 0;
                    default: m_st[j] = 0;
                endcase
            end
        end
    end

    always @(posedge CK) begin
        #1;
        if (cmp_en) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("busy%0d", j), int'(busy_s[j]), int'(m_st[j] == 1));
                chk($sformatf("valid%0d", j), int'(valid_s[j]), int'(m_st[j] == 2));
                chk($sformatf("din%0d", j), int'(din_s[j]), int'(m_din[j]));
                if (m_st[j] != 1) begin
                    chk($sformatf("resp%0d", j), int'(resp_s[j]), int'(m_resp[j]));
                    chk($sformatf("mis%0d", j), int'(mis_s[j]), int'(m_mis[j]));
                    chk($sformatf("fail%0d", j), int'(fail_s[j]), int'(m_fail[j]));
                end
            end
        end
    end

    task automatic launch(input int j, input logic [7:0] g);
        @(negedge CK);
        gold_s[j]  = g;
        start_s[j] = 1'b1;
        @(posedge CK);
        #1;
        start_s[j] = 1'b0;
    endtask

    task automatic wait_valid(input int j, output int n);
        n = 0;
        while (!valid_s[j] && n < 200) begin
            @(posedge CK);
            #1;
            n++;
        end
    endtask

    task automatic release_resp(input int j, input string nm);
        @(negedge CK);
        ready_s[j] = 1'b1;
        @(posedge CK);
        #1;
        chk(nm, int'(valid_s[j]), 0);
        @(negedge CK);
        ready_s[j] = 1'b0;
    endtask

    task automatic chk_result(input string nm, input logic [7:0] r,
                              input logic mi, input logic [2:0] f);
        chk({nm, "_resp"}, int'(resp_s[0]), int'(r));
        chk({nm, "_mis"}, int'(mis_s[0]), int'(mi));
        chk({nm, "_fidx"}, int'(fail_s[0]), int'(f));
    endtask

    initial begin
        int n;
        int r1;
        int r2;
        logic prev;
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            start_s[j] = 1'b0;
            ready_s[j] = 1'b0;
            gold_s[j]  = 8'd0;
        end
        sel_s[0] = 0;
        sel_s[1] = 1;
        #2 reset = 1'b0;
        repeat (3) @(negedge CK);
        cmp_en = 1;
        @(posedge CK);
        #1;
        chk("rst_busy", int'(busy_s[0]), 0);
        chk("rst_valid", int'(valid_s[0]), 0);
        chk("rst_din", int'(din_s[0]), 0);
        chk_result("rst", 8'h00, 1'b0, 3'd0);
        @(negedge CK);
        reset = 1'b1;

        launch(0, 8'h80);
        wait_valid(0, n);
        chk("lat_and", n, 16);
        chk_result("and80", 8'h80, 1'b0, 3'd0);
        release_resp(0, "rel1");

        launch(0, 8'h81);
        wait_valid(0, n);
        chk("lat_81", n, 16);
        chk_result("and81", 8'h80, 1'b1, 3'd0);
        release_resp(0, "rel2");

        launch(0, 8'hC0);
        wait_valid(0, n);
        chk_result("andC0", 8'h80, 1'b1, 3'd6);
        for (int k = 0; k < 20; k++) begin
            @(negedge CK);
            start_s[0] = (k % 4 == 0);
            @(posedge CK);
            #1;
            chk("hold_valid", int'(valid_s[0]), 1);
            chk_result("hold", 8'h80, 1'b1, 3'd6);
        end
        @(negedge CK);
        start_s[0] = 1'b0;
        ready_s[0] = 1'b1;
        @(posedge CK);
        #1;
        chk("hs_valid", int'(valid_s[0]), 0);
        @(negedge CK);
        ready_s[0] = 1'b0;
        gold_s[0]  = 8'h80;
        start_s[0] = 1'b1;
        @(posedge CK);
        #1;
        start_s[0] = 1'b0;
        chk("b2b_busy", int'(busy_s[0]), 1);
        wait_valid(0, n);
        chk("lat_b2b", n, 16);
        chk_result("b2b", 8'h80, 1'b0, 3'd0);
        release_resp(0, "rel3");

        launch(0, 8'h80);
        repeat (7) @(posedge CK);
        #1;
        chk("mid_din", int'(din_s[0]), 3);
        @(negedge CK);
        reset = 1'b0;
        #1;
        chk("ab_busy", int'(busy_s[0]), 0);
        chk("ab_valid", int'(valid_s[0]), 0);
        chk("ab_din", int'(din_s[0]), 0);
        chk_result("ab", 8'h00, 1'b0, 3'd0);
        @(negedge CK);
        reset = 1'b1;
        launch(0, 8'h80);
        wait_valid(0, n);
        chk("lat_rst", n, 16);
        chk_result("after_rst", 8'h80, 1'b0, 3'd0);
        release_resp(0, "rel4");

        launch(1, 8'h96);
        chk("xor_din0", int'(din_s[1]), 0);
        for (int k = 1; k < 8; k++) begin
            @(posedge CK);
            #1;
            chk("xor_din", int'(din_s[1]), k);
            chk("xor_busy", int'(busy_s[1]), 1);
        end
        @(posedge CK);
        #1;
        chk("xor_valid", int'(valid_s[1]), 1);
        chk("xor_resp", int'(resp_s[1]), 8'h96);
        chk("xor_mis", int'(mis_s[1]), 0);
        release_resp(1, "rel5");

        @(negedge CK);
        gold_s[0]  = 8'h80;
        ready_s[0] = 1'b1;
        start_s[0] = 1'b1;
        r1 = -1;
        r2 = -1;
        prev = 1'b0;
        for (int e = 0; e < 80; e++) begin
            @(posedge CK);
            #1;
            if (valid_s[0] && !prev) begin
                if (r1 < 0) r1 = e;
                else if (r2 < 0) r2 = e;
            end
            prev = valid_s[0];
        end
        chk("cont_seen", int'(r2 >= 0), 1);
        chk("cont_period", r2 - r1, 18);
        @(negedge CK);
        start_s[0] = 1'b0;
        repeat (40) @(posedge CK);
        @(negedge CK);
        ready_s[0] = 1'b0;
        #1;
        chk("end_busy", int'(busy_s[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_sweep_capture.md
# vector_sweep_capture

Synthesizable on-chip stimulus-and-capture stage that sits directly upstream and downstream of a benchmark circuit under trojan test. On `start` it drives every N_IN-bit input pattern to the circuit in ascending order, from 0 to 2^N_IN−1. After a programmable settle window it samples the circuit's single-bit output for each pattern and packs the results into a response word. It then compares the response word with a golden word and holds the result until a consumer accepts it. This replaces file-based exhaustive sweeps with a hardware sweep usable in silicon.

## Interface
Parameters:
- N_IN, default 3: width of circuit input bus. Legal range 1..8.
- SETTLE, default 1: extra cycles each pattern is held before sampling. Legal range 0..15.

Ports:
- CK  in  1  clock. All state is updated on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins a sweep. Sampled only in IDLE.
- golden  in  2^N_IN  expected response word. Bit i is the expected output for pattern i. Latched on the accepted start.
- dut_in  out  N_IN  registered pattern driven to the circuit.
- dut_out  in  1  circuit output.
- busy  out  1  high in DRIVE.
- resp_valid  out  1  high in DONE.
- resp_ready  in  1  consumer accept.
- resp  out  2^N_IN  captured response word. Bit i is dut_out sampled for pattern i.
- mismatch  out  1  resp differs from the latched golden word.
- fail_idx  out  N_IN  lowest index i where resp[i] differs from golden[i]. It is 0 when there is no mismatch.

## Operation
FSM states: IDLE, DRIVE, DONE.
- IDLE, start=1: latch golden, set idx=0, cnt=0, dut_in=0, clear resp/mismatch/fail_idx, go to DRIVE. With start=0, stay in IDLE.
- DRIVE, cnt<SETTLE: cnt++, dut_in unchanged.
- DRIVE, cnt==SETTLE: set resp[idx] ← dut_out.
  - If dut_out≠golden[idx] and no earlier mismatch, set mismatch=1 and fail_idx=idx.
  - Reset cnt to 0.
  - If idx==2^N_IN−1, go to DONE. Otherwise idx++ and dut_in ← idx+1.
- DONE: resp_valid=1. resp, mismatch and fail_idx are held stable.
  - resp_ready=1 goes to IDLE.
  - resp_ready=0 stays in DONE. No timeout.
- start is ignored in DRIVE and DONE. It is not queued.
- The mismatch decision for the final pattern is visible in the same cycle resp_valid rises.
- dut_in holds its last value (all ones) in DONE and IDLE until the next start.
- idx never wraps inside a sweep. Terminal detection is idx==all-ones.

## Timing
- Reset values: busy=0, resp_valid=0, resp=0, mismatch=0, fail_idx=0, dut_in=0, state IDLE.
- Reset asserted at any point, including mid-sweep or in DONE, aborts immediately to those values. There is no partial result.
- Each pattern occupies SETTLE+1 cycles. dut_in is stable for all of them, and sampling happens on the last edge.
- Sweep latency: resp_valid rises (SETTLE+1)·2^N_IN edges after the edge that accepts start. For N_IN=3, SETTLE=1 this is 16 cycles.
- The handshake completes on the edge with resp_valid&resp_ready. resp_valid is low the following cycle.
- A start asserted in that following cycle is accepted, so back-to-back sweeps are spaced by exactly one IDLE cycle.
- dut_out must be combinationally valid within SETTLE+1 cycles of a dut_in change. Any circuit flops must be reset outside this block.

## Structure
- Package sweep_pkg: sweep_state_t enum {IDLE, DRIVE, DONE}; localparam helper for NVEC=2**N_IN.
- Single module. The settle counter and index counter are inline. No sub-module is warranted.

## Test plan
- N_IN=3, SETTLE=1, circuit is a 3-input AND, golden=8'b1000_0000, start pulse -> resp_valid after 16 cycles, resp=8'h80, mismatch=0, fail_idx=0.
- Same setup, golden=8'h81 -> mismatch=1, fail_idx=0. A second bench run with golden=8'hC0 -> fail_idx=6.
- Hold resp_ready=0 for 20 cycles in DONE -> resp/mismatch stable, start pulses ignored. Then resp_ready=1 -> IDLE next cycle. A start the cycle after is accepted.
- Assert reset (low) at cycle 7 of a sweep -> all outputs 0, state IDLE. A later start produces a full correct sweep.
- SETTLE=0, circuit is XOR of all inputs -> resp=8'h96 after 8 cycles. dut_in steps 0..7, one per cycle.
- start held high continuously -> consecutive sweeps each produce resp_valid, separated by one IDLE cycle after each accept.
